// File: rtl/busy_table_pkg.sv
// Shared constants for the busy table: physical register file size and the
// width of the registered busy count.
package busy_table_pkg;

  localparam int PREG_NUM = 64;
  localparam int PREG_W   = $clog2(PREG_NUM);
  localparam int CNT_W    = $clog2(PREG_NUM + 1);

endpackage

// File: rtl/busy_table_if.sv
// Dispatch / writeback / ROB-walk request bundle for the busy table.
// The master modport is the requester side; the slave modport is the table itself.
interface busy_table_if;
  import busy_table_pkg::*;

  logic [PREG_W-1:0] disp2bt_instr0_rs1;
  logic              bt2disp_instr0_rs1_busy;
  logic [PREG_W-1:0] disp2bt_instr0_rs2;
  logic              bt2disp_instr0_rs2_busy;
  logic [PREG_W-1:0] disp2bt_instr1_rs1;
  logic              bt2disp_instr1_rs1_busy;
  logic [PREG_W-1:0] disp2bt_instr1_rs2;
  logic              bt2disp_instr1_rs2_busy;

  logic              disp2bt_alloc_instr0_rd_en;
  logic [PREG_W-1:0] disp2bt_alloc_instr0_rd;
  logic              disp2bt_alloc_instr1_rd_en;
  logic [PREG_W-1:0] disp2bt_alloc_instr1_rd;

  logic              wb2bt_free_instr0_rd_en;
  logic [PREG_W-1:0] wb2bt_free_instr0_rd;
  logic              wb2bt_free_instr1_rd_en;
  logic [PREG_W-1:0] wb2bt_free_instr1_rd;

  logic              rob2bt_walk_instr0_rd_en;
  logic [PREG_W-1:0] rob2bt_walk_instr0_rd;
  logic              rob2bt_walk_instr1_rd_en;
  logic [PREG_W-1:0] rob2bt_walk_instr1_rd;

  logic              flush_valid;
  logic [CNT_W-1:0]  bt_busy_count;

  modport master (
    output disp2bt_instr0_rs1, disp2bt_instr0_rs2,
    output disp2bt_instr1_rs1, disp2bt_instr1_rs2,
    output disp2bt_alloc_instr0_rd_en, disp2bt_alloc_instr0_rd,
    output disp2bt_alloc_instr1_rd_en, disp2bt_alloc_instr1_rd,
    output wb2bt_free_instr0_rd_en, wb2bt_free_instr0_rd,
    output wb2bt_free_instr1_rd_en, wb2bt_free_instr1_rd,
    output rob2bt_walk_instr0_rd_en, rob2bt_walk_instr0_rd,
    output rob2bt_walk_instr1_rd_en, rob2bt_walk_instr1_rd,
    output flush_valid,
    input  bt2disp_instr0_rs1_busy, bt2disp_instr0_rs2_busy,
    input  bt2disp_instr1_rs1_busy, bt2disp_instr1_rs2_busy,
    input  bt_busy_count
  );

  modport slave (
    input  disp2bt_instr0_rs1, disp2bt_instr0_rs2,
    input  disp2bt_instr1_rs1, disp2bt_instr1_rs2,
    input  disp2bt_alloc_instr0_rd_en, disp2bt_alloc_instr0_rd,
    input  disp2bt_alloc_instr1_rd_en, disp2bt_alloc_instr1_rd,
    input  wb2bt_free_instr0_rd_en, wb2bt_free_instr0_rd,
    input  wb2bt_free_instr1_rd_en, wb2bt_free_instr1_rd,
    input  rob2bt_walk_instr0_rd_en, rob2bt_walk_instr0_rd,
    input  rob2bt_walk_instr1_rd_en, rob2bt_walk_instr1_rd,
    input  flush_valid,
    output bt2disp_instr0_rs1_busy, bt2disp_instr0_rs2_busy,
    output bt2disp_instr1_rs1_busy, bt2disp_instr1_rs2_busy,
    output bt_busy_count
  );

endinterface

// File: rtl/busy_table_popcount.sv
// Combinational population count of an N-bit vector; shared with the perf counters.
module bt_popcount #(
  parameter int N     = 64,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     vec,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CNT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/busy_table.sv
// Per-physical-register busy bitmap: dispatch sets, writeback/ROB-walk clear,
// with same-cycle bypass on the source read ports and a registered busy count.
module busy_table
  import busy_table_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  busy_table_if.slave  bt
);

  logic [PREG_NUM-1:0] busy_vec;
  logic [PREG_NUM-1:0] busy_nxt;
  logic [PREG_NUM-1:0] set_vec;
  logic [PREG_NUM-1:0] clr_vec;
  logic [CNT_W-1:0]    count_nxt;
  logic                alloc0_live;
  logic                alloc1_live;

  // Allocation is squashed during a flush; clears keep draining so the walk completes.
  assign alloc0_live = bt.disp2bt_alloc_instr0_rd_en & ~bt.flush_valid;
  assign alloc1_live = bt.disp2bt_alloc_instr1_rd_en & ~bt.flush_valid;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (alloc0_live)                 set_vec[bt.disp2bt_alloc_instr0_rd] = 1'b1;
    if (alloc1_live)                 set_vec[bt.disp2bt_alloc_instr1_rd] = 1'b1;
    if (bt.wb2bt_free_instr0_rd_en)  clr_vec[bt.wb2bt_free_instr0_rd]    = 1'b1;
    if (bt.wb2bt_free_instr1_rd_en)  clr_vec[bt.wb2bt_free_instr1_rd]    = 1'b1;
    if (bt.rob2bt_walk_instr0_rd_en) clr_vec[bt.rob2bt_walk_instr0_rd]   = 1'b1;
    if (bt.rob2bt_walk_instr1_rd_en) clr_vec[bt.rob2bt_walk_instr1_rd]   = 1'b1;
    set_vec[0] = 1'b0;
  end

  // Set beats clear: a same-cycle free and re-allocate of one preg leaves it busy.
  always_comb begin
    busy_nxt    = (busy_vec & ~clr_vec) | set_vec;
    busy_nxt[0] = 1'b0;
  end

  function automatic logic read_busy(input logic [PREG_W-1:0] addr,
                                     input logic              see_instr0);
    logic intra;
    intra = see_instr0 & alloc0_live &
            (bt.disp2bt_alloc_instr0_rd == addr) & (addr != '0);
    return (busy_vec[addr] & ~clr_vec[addr]) | intra;
  endfunction

  assign bt.bt2disp_instr0_rs1_busy = read_busy(bt.disp2bt_instr0_rs1, 1'b0);
  assign bt.bt2disp_instr0_rs2_busy = read_busy(bt.disp2bt_instr0_rs2, 1'b0);
  assign bt.bt2disp_instr1_rs1_busy = read_busy(bt.disp2bt_instr1_rs1, 1'b1);
  assign bt.bt2disp_instr1_rs2_busy = read_busy(bt.disp2bt_instr1_rs2, 1'b1);

  bt_popcount #(
    .N     (PREG_NUM),
    .CNT_W (CNT_W)
  ) u_popcount (
    .vec   (busy_nxt),
    .count (count_nxt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_vec         <= '0;
      bt.bt_busy_count <= '0;
    end else begin
      busy_vec         <= busy_nxt;
      bt.bt_busy_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_busy_table.sv
// Randomized and directed bench for busy_table against a per-preg behavioural model.
module tb_busy_table;
  import busy_table_pkg::*;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;
  bit   model_busy [PREG_NUM];

  busy_table_if bt_if ();

  busy_table dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bt      (bt_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit alloc_hits(input int i);
    if (bt_if.flush_valid || i == 0) return 1'b0;
    return (bt_if.disp2bt_alloc_instr0_rd_en && int'(bt_if.disp2bt_alloc_instr0_rd) == i) ||
           (bt_if.disp2bt_alloc_instr1_rd_en && int'(bt_if.disp2bt_alloc_instr1_rd) == i);
  endfunction

  function automatic bit clear_hits(input int i);
    return (bt_if.wb2bt_free_instr0_rd_en  && int'(bt_if.wb2bt_free_instr0_rd)  == i) ||
           (bt_if.wb2bt_free_instr1_rd_en  && int'(bt_if.wb2bt_free_instr1_rd)  == i) ||
           (bt_if.rob2bt_walk_instr0_rd_en && int'(bt_if.rob2bt_walk_instr0_rd) == i) ||
           (bt_if.rob2bt_walk_instr1_rd_en && int'(bt_if.rob2bt_walk_instr1_rd) == i);
  endfunction

  // Source is busy if recorded and not produced this cycle; instr1 also sees instr0's new prd.
  function automatic int exp_busy(input int addr, input bit is_instr1);
    bit b;
    b = model_busy[addr] && !clear_hits(addr);
    if (is_instr1 && addr != 0 && !bt_if.flush_valid &&
        bt_if.disp2bt_alloc_instr0_rd_en && int'(bt_if.disp2bt_alloc_instr0_rd) == addr)
      b = 1'b1;
    return int'(b);
  endfunction

  function automatic int model_count();
    int n;
    n = 0;
    foreach (model_busy[i]) n += int'(model_busy[i]);
    return n;
  endfunction

  always @(negedge reset_n) begin
    foreach (model_busy[i]) model_busy[i] = 1'b0;
  end

  always @(posedge clock) begin
    if (reset_n) begin
      for (int i = 1; i < PREG_NUM; i++) begin
        if (alloc_hits(i))      model_busy[i] = 1'b1;
        else if (clear_hits(i)) model_busy[i] = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      check("rd_i0_rs1", int'(bt_if.bt2disp_instr0_rs1_busy), exp_busy(int'(bt_if.disp2bt_instr0_rs1), 1'b0));
      check("rd_i0_rs2", int'(bt_if.bt2disp_instr0_rs2_busy), exp_busy(int'(bt_if.disp2bt_instr0_rs2), 1'b0));
      check("rd_i1_rs1", int'(bt_if.bt2disp_instr1_rs1_busy), exp_busy(int'(bt_if.disp2bt_instr1_rs1), 1'b1));
      check("rd_i1_rs2", int'(bt_if.bt2disp_instr1_rs2_busy), exp_busy(int'(bt_if.disp2bt_instr1_rs2), 1'b1));
      check("busy_count", int'(bt_if.bt_busy_count), model_count());
    end
  end

  task automatic idle();
    bt_if.disp2bt_instr0_rs1         = '0;
    bt_if.disp2bt_instr0_rs2         = '0;
    bt_if.disp2bt_instr1_rs1         = '0;
    bt_if.disp2bt_instr1_rs2         = '0;
    bt_if.disp2bt_alloc_instr0_rd_en = 1'b0;
    bt_if.disp2bt_alloc_instr0_rd    = '0;
    bt_if.disp2bt_alloc_instr1_rd_en = 1'b0;
    bt_if.disp2bt_alloc_instr1_rd    = '0;
    bt_if.wb2bt_free_instr0_rd_en    = 1'b0;
    bt_if.wb2bt_free_instr0_rd       = '0;
    bt_if.wb2bt_free_instr1_rd_en    = 1'b0;
    bt_if.wb2bt_free_instr1_rd       = '0;
    bt_if.rob2bt_walk_instr0_rd_en   = 1'b0;
    bt_if.rob2bt_walk_instr0_rd      = '0;
    bt_if.rob2bt_walk_instr1_rd_en   = 1'b0;
    bt_if.rob2bt_walk_instr1_rd      = '0;
    bt_if.flush_valid                = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [PREG_W-1:0] rand_idx();
    if ($urandom_range(0, 3) == 0) return PREG_W'($urandom_range(0, PREG_NUM - 1));
    return PREG_W'($urandom_range(0, 15));
  endfunction

  task automatic apply_stimulus();
    bt_if.disp2bt_instr0_rs1         = rand_idx();
    bt_if.disp2bt_instr0_rs2         = rand_idx();
    bt_if.disp2bt_instr1_rs1         = rand_idx();
    bt_if.disp2bt_instr1_rs2         = rand_idx();
    bt_if.disp2bt_alloc_instr0_rd_en = ($urandom_range(0, 1) == 1);
    bt_if.disp2bt_alloc_instr0_rd    = rand_idx();
    bt_if.disp2bt_alloc_instr1_rd_en = ($urandom_range(0, 1) == 1);
    bt_if.disp2bt_alloc_instr1_rd    = rand_idx();
    bt_if.wb2bt_free_instr0_rd_en    = ($urandom_range(0, 2) == 0);
    bt_if.wb2bt_free_instr0_rd       = rand_idx();
    bt_if.wb2bt_free_instr1_rd_en    = ($urandom_range(0, 2) == 0);
    bt_if.wb2bt_free_instr1_rd       = rand_idx();
    bt_if.rob2bt_walk_instr0_rd_en   = ($urandom_range(0, 4) == 0);
    bt_if.rob2bt_walk_instr0_rd      = rand_idx();
    bt_if.rob2bt_walk_instr1_rd_en   = ($urandom_range(0, 4) == 0);
    bt_if.rob2bt_walk_instr1_rd      = rand_idx();
    bt_if.flush_valid                = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    idle();
    do_reset();

    // Reset state and first allocation.
    bt_if.disp2bt_instr0_rs1 = 6'd5; bt_if.disp2bt_instr0_rs2 = 6'd5;
    bt_if.disp2bt_instr1_rs1 = 6'd5; bt_if.disp2bt_instr1_rs2 = 6'd5;
    #3;
    check("lit_reset_i0rs1", int'(bt_if.bt2disp_instr0_rs1_busy), 0);
    check("lit_reset_i1rs2", int'(bt_if.bt2disp_instr1_rs2_busy), 0);
    check("lit_reset_count", int'(bt_if.bt_busy_count), 0);
    bt_if.disp2bt_alloc_instr0_rd_en = 1'b1; bt_if.disp2bt_alloc_instr0_rd = 6'd5;
    step();
    bt_if.disp2bt_instr0_rs1 = 6'd5;
    #3;
    check("lit_alloc5_busy", int'(bt_if.bt2disp_instr0_rs1_busy), 1);
    check("lit_alloc5_count", int'(bt_if.bt_busy_count), 1);

    // Writeback bypass.
    do_reset();
    bt_if.disp2bt_alloc_instr0_rd_en = 1'b1; bt_if.disp2bt_alloc_instr0_rd = 6'd7;
    step();
    step();
    bt_if.wb2bt_free_instr0_rd_en = 1'b1; bt_if.wb2bt_free_instr0_rd = 6'd7;
    bt_if.disp2bt_instr0_rs1 = 6'd7;
    #3;
    check("lit_wb_bypass", int'(bt_if.bt2disp_instr0_rs1_busy), 0);
    check("lit_wb_pre_count", int'(bt_if.bt_busy_count), 1);
    step();
    bt_if.disp2bt_instr0_rs1 = 6'd7;
    #3;
    check("lit_wb_after", int'(bt_if.bt2disp_instr0_rs1_busy), 0);
    check("lit_wb_count", int'(bt_if.bt_busy_count), 0);

    // Intra-group dependency only visible to instr1.
    bt_if.disp2bt_alloc_instr0_rd_en = 1'b1; bt_if.disp2bt_alloc_instr0_rd = 6'd9;
    bt_if.disp2bt_instr1_rs2 = 6'd9; bt_if.disp2bt_instr0_rs1 = 6'd9;
    #3;
    check("lit_intra_i1", int'(bt_if.bt2disp_instr1_rs2_busy), 1);
    check("lit_intra_i0", int'(bt_if.bt2disp_instr0_rs1_busy), 0);
    step();

    // Preg 0 is never busy.
    bt_if.disp2bt_alloc_instr0_rd_en = 1'b1; bt_if.disp2bt_alloc_instr0_rd = 6'd0;
    bt_if.disp2bt_instr1_rs1 = 6'd0;
    #3;
    check("lit_p0_intra", int'(bt_if.bt2disp_instr1_rs1_busy), 0);
    step();
    #3;
    check("lit_p0_read", int'(bt_if.bt2disp_instr0_rs1_busy), 0);
    check("lit_p0_count", int'(bt_if.bt_busy_count), 1);

    // Alloc beats clear, then flush blocks alloc but not walk.
    bt_if.disp2bt_alloc_instr0_rd_en = 1'b1; bt_if.disp2bt_alloc_instr0_rd = 6'd12;
    step();
    bt_if.disp2bt_alloc_instr1_rd_en = 1'b1; bt_if.disp2bt_alloc_instr1_rd = 6'd12;
    bt_if.rob2bt_walk_instr0_rd_en = 1'b1;   bt_if.rob2bt_walk_instr0_rd = 6'd12;
    step();
    bt_if.disp2bt_instr0_rs1 = 6'd12;
    #3;
    check("lit_alloc_wins", int'(bt_if.bt2disp_instr0_rs1_busy), 1);
    check("lit_alloc_wins_cnt", int'(bt_if.bt_busy_count), 2);
    bt_if.flush_valid = 1'b1;
    bt_if.disp2bt_alloc_instr0_rd_en = 1'b1; bt_if.disp2bt_alloc_instr0_rd = 6'd20;
    bt_if.rob2bt_walk_instr1_rd_en = 1'b1;   bt_if.rob2bt_walk_instr1_rd = 6'd12;
    step();
    bt_if.disp2bt_instr0_rs1 = 6'd20; bt_if.disp2bt_instr0_rs2 = 6'd12;
    #3;
    check("lit_flush_no_alloc", int'(bt_if.bt2disp_instr0_rs1_busy), 0);
    check("lit_flush_walk", int'(bt_if.bt2disp_instr0_rs2_busy), 0);
    check("lit_flush_count", int'(bt_if.bt_busy_count), 1);

    // Asynchronous reset mid-cycle.
    bt_if.disp2bt_alloc_instr0_rd_en = 1'b1; bt_if.disp2bt_alloc_instr0_rd = 6'd63;
    step();
    bt_if.disp2bt_alloc_instr1_rd_en = 1'b1; bt_if.disp2bt_alloc_instr1_rd = 6'd1;
    step();
    bt_if.disp2bt_instr0_rs1 = 6'd63; bt_if.disp2bt_instr0_rs2 = 6'd1;
    #2;
    check("lit_pre_rst_count", int'(bt_if.bt_busy_count), 3);
    reset_n = 1'b0;
    #1;
    check("lit_rst_63", int'(bt_if.bt2disp_instr0_rs1_busy), 0);
    check("lit_rst_1", int'(bt_if.bt2disp_instr0_rs2_busy), 0);
    check("lit_rst_count", int'(bt_if.bt_busy_count), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      apply_stimulus();
      @(posedge clock);
      #1;
    end
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/busy_table.md
Name: busy_table

Overview:
- Per-physical-register busy bitmap in the ISU; it is the responder to dispatch's busy-table read and allocate ports.
- Dispatch marks a newly allocated prd busy and reads source busy state to set the issue-queue sleep bits (src state).
- Writeback ports clear bits when results are produced. ROB walk ports clear bits of squashed prds after a flush.
- A registered busy count is provided for perf counters and debug.

Parameters:
PREG_NUM, 64, number of physical registers.
PREG_W, 6, preg index width (log2 PREG_NUM); equals `PREG_RANGE width.

Ports:
clock  in  1  core clock
reset_n  in  1  asynchronous active-low reset
disp2bt_instr0_rs1  in  6  read addr port 0
bt2disp_instr0_rs1_busy  out  1  busy for port 0
disp2bt_instr0_rs2  in  6  read addr port 1
bt2disp_instr0_rs2_busy  out  1  busy for port 1
disp2bt_instr1_rs1  in  6  read addr port 2
bt2disp_instr1_rs1_busy  out  1  busy for port 2
disp2bt_instr1_rs2  in  6  read addr port 3
bt2disp_instr1_rs2_busy  out  1  busy for port 3
disp2bt_alloc_instr0_rd_en  in  1  set busy for instr0 prd
disp2bt_alloc_instr0_rd  in  6  instr0 prd
disp2bt_alloc_instr1_rd_en  in  1  set busy for instr1 prd
disp2bt_alloc_instr1_rd  in  6  instr1 prd
wb2bt_free_instr0_rd_en  in  1  writeback clear port 0
wb2bt_free_instr0_rd  in  6  writeback preg 0
wb2bt_free_instr1_rd_en  in  1  writeback clear port 1
wb2bt_free_instr1_rd  in  6  writeback preg 1
rob2bt_walk_instr0_rd_en  in  1  flush-walk clear port 0
rob2bt_walk_instr0_rd  in  6  squashed prd 0
rob2bt_walk_instr1_rd_en  in  1  flush-walk clear port 1
rob2bt_walk_instr1_rd  in  6  squashed prd 1
flush_valid  in  1  flush this cycle
bt_busy_count  out  7  registered count of busy entries

Behaviour:
- State: busy_vec[PREG_NUM-1:0] flops. Reset (async, reset_n low) clears all bits to 0 and bt_busy_count to 0. Reset mid-operation discards everything, with no pending state.
- Preg 0 is hardwired not-busy. Writes to index 0 are ignored; reads of index 0 return 0.
- Read ports are combinational, with 0-cycle latency:
  - busy = busy_vec[addr] & ~clr_hit(addr) | intra_hit.
  - clr_hit: a same-cycle enabled wb or walk port targets addr (bypass, so a source produced this cycle is never put to sleep).
  - intra_hit, instr1 ports only: alloc_instr0_rd_en && alloc_instr0_rd==addr && addr!=0 (instr1 depends on instr0 of the same group).
  - instr0 ports never see same-cycle allocs.
- Gating: alloc ports are suppressed when flush_valid=1; the wb and walk ports stay active during flush.
- Next state per entry i: set if any alloc port hits i, else clear if any wb or walk port hits i, else hold. Alloc wins over a same-cycle clear (this is a reuse of a freed preg).
- Duplicate indices in the same cycle (both allocs, or both clears) are legal and idempotent.
- Updates are visible to the state and to read ports 1 cycle after the write cycle; the same-cycle visibility cases are the bypass rules above.
- bt_busy_count is registered popcount(next busy_vec), updated every cycle. Range 0..PREG_NUM-1, so no overflow at 7 bits.
- No state machine; the block is a pure bitmap with priority-encoded update. There is no handshake: all requests are accepted unconditionally.

Decomposition:
- The PREG_RANGE width and PREG_NUM constants come from the shared defines header.
- No typedefs are needed.
- Sub-module bt_popcount (combinational PREG_NUM-bit popcount) is the natural split and is reused by perf counters.

Test Plan:
- Reset, then read all four ports at addr 5 -> busy=0 and bt_busy_count=0. Alloc 5 at t0 -> at t1, read addr 5 busy=1 and count=1.
- Alloc 7 at t0; at t2 assert wb port 0 for 7 while reading rs1=7 -> busy=0 in the same cycle (bypass); at t3 busy=0 and count returns to 0.
- Same cycle: alloc_instr0 rd=9 with instr1_rs2=9 -> bt2disp_instr1_rs2_busy=1 and bt2disp_instr0_rs1_busy (addr 9)=0.
- Alloc 0 and read addr 0 -> state unchanged, busy=0, count unchanged.
- Busy 12; same cycle, alloc 12 plus walk-clear 12 -> 12 stays busy. Then flush_valid=1 with alloc 20 plus walk-clear 12 -> 20 not set, 12 cleared.
- Alloc 63 (busy) and 1 over 2 cycles, then pulse reset_n low mid-cycle -> all bits clear asynchronously and count=0.
